// File: rtl/dmem_responder_if.sv
// Bus bundle for the data-memory responder: core load/store port plus the host
// (wishbone-style) management port.
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_data_addr_M;
  logic [DATA_WIDTH-1:0] i_write_data_M;
  logic                  i_mem_write_M;
  logic [DATA_WIDTH-1:0] o_read_data_M;
  logic                  o_stall_M;
  logic                  o_range_err;

  logic                  i_host_cyc;
  logic                  i_host_stb;
  logic                  i_host_we;
  logic [DATA_WIDTH-1:0] i_host_addr;
  logic [DATA_WIDTH-1:0] i_host_wdata;
  logic                  o_host_ack;
  logic [DATA_WIDTH-1:0] o_host_rdata;

  modport master (
    output i_data_addr_M, i_write_data_M, i_mem_write_M,
    input  o_read_data_M, o_stall_M, o_range_err,
    output i_host_cyc, i_host_stb, i_host_we, i_host_addr, i_host_wdata,
    input  o_host_ack, o_host_rdata
  );

  modport slave (
    input  i_data_addr_M, i_write_data_M, i_mem_write_M,
    output o_read_data_M, o_stall_M, o_range_err,
    input  i_host_cyc, i_host_stb, i_host_we, i_host_addr, i_host_wdata,
    output o_host_ack, o_host_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed synchronous data RAM serving the core's memory stage, with a
// 3-state host port that preempts the core and stalls it for one cycle.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_responder_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {H_IDLE, H_ACCESS, H_ACK} hstate_e;

  hstate_e               state;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic [ADDR_BITS-1:0]  idx;
  logic                  in_range;
  logic                  core_we;

  logic [ADDR_BITS-1:0]  h_idx;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic                  h_we;

  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic                  ack_q;
  logic                  err_q;

  assign idx      = bus.i_data_addr_M[ADDR_BITS+1:2];
  assign in_range = (bus.i_data_addr_M[DATA_WIDTH-1:ADDR_BITS+2] == '0);
  assign core_we  = bus.i_mem_write_M && in_range && (state != H_ACCESS);

  // Byte-offset bits and the host's upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_data_addr_M[1:0], bus.i_host_addr[1:0],
                              bus.i_host_addr[DATA_WIDTH-1:ADDR_BITS+2]};

  // Single write port: the host owns it during H_ACCESS, the core otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == H_ACCESS) begin
        if (h_we) ram[h_idx] <= h_wdata;
      end else if (core_we) begin
        ram[idx] <= bus.i_write_data_M;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= H_IDLE;
      rd_q     <= '0;
      hrdata_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      h_idx    <= '0;
      h_wdata  <= '0;
      h_we     <= 1'b0;
    end else begin
      // The core reads every cycle, so any out-of-range address is an error.
      if (!in_range) err_q <= 1'b1;
      if (state != H_ACCESS) rd_q <= in_range ? ram[idx] : '0;
      ack_q <= 1'b0;
      case (state)
        H_IDLE: if (bus.i_host_cyc && bus.i_host_stb) begin
          state   <= H_ACCESS;
          h_idx   <= bus.i_host_addr[ADDR_BITS+1:2];
          h_wdata <= bus.i_host_wdata;
          h_we    <= bus.i_host_we;
        end
        H_ACCESS: begin
          state <= H_ACK;
          ack_q <= 1'b1;
          if (!h_we) hrdata_q <= ram[h_idx];
        end
        H_ACK:   state <= H_IDLE;
        default: state <= H_IDLE;
      endcase
    end
  end

  assign bus.o_read_data_M = rd_q;
  assign bus.o_stall_M     = (state == H_ACCESS);
  assign bus.o_range_err   = err_q;
  assign bus.o_host_ack    = ack_q;
  assign bus.o_host_rdata  = hrdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: host preload/readback, core load/store,
// range errors, host preemption and reset during a host access.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  dmem_responder_if #(.DATA_WIDTH(32)) bus ();

  dmem_responder #(.DATA_WIDTH(32), .ADDR_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full host transaction; cyc/stb drop right after the request is latched.
  task automatic host_op(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    bus.i_host_cyc = 1'b1; bus.i_host_stb = 1'b1; bus.i_host_we = we;
    bus.i_host_addr = addr; bus.i_host_wdata = wdata;
    tick();
    bus.i_host_cyc = 1'b0; bus.i_host_stb = 1'b0;
    chk({tag, " stall_access"}, {31'd0, bus.o_stall_M}, 32'd1);
    chk({tag, " ack_early"},    {31'd0, bus.o_host_ack}, 32'd0);
    tick();
    chk({tag, " ack"},          {31'd0, bus.o_host_ack}, 32'd1);
    chk({tag, " stall_ack"},    {31'd0, bus.o_stall_M}, 32'd0);
    chk({tag, " rdata"},        bus.o_host_rdata, exp_rdata);
    tick();
    chk({tag, " ack_pulse"},    {31'd0, bus.o_host_ack}, 32'd0);
  endtask

  initial begin
    bus.i_data_addr_M = '0; bus.i_write_data_M = '0; bus.i_mem_write_M = 1'b0;
    bus.i_host_cyc = 1'b0; bus.i_host_stb = 1'b0; bus.i_host_we = 1'b0;
    bus.i_host_addr = '0; bus.i_host_wdata = '0;
    rst = 1'b1;
    tick(); tick();
    chk("rst rd",     bus.o_read_data_M, 32'd0);
    chk("rst stall",  {31'd0, bus.o_stall_M}, 32'd0);
    chk("rst err",    {31'd0, bus.o_range_err}, 32'd0);
    chk("rst ack",    {31'd0, bus.o_host_ack}, 32'd0);
    chk("rst hrdata", bus.o_host_rdata, 32'd0);
    rst = 1'b0;

    // Host write then readback; write leaves rdata unchanged; host index wraps.
    host_op("h_wr10", 1'b1, 32'h10,  32'hDEADBEEF, 32'h0);
    host_op("h_rd10", 1'b0, 32'h10,  32'h0,        32'hDEADBEEF);
    host_op("h_wr00", 1'b1, 32'h0,   32'h0BADC0DE, 32'hDEADBEEF);
    host_op("h_wrap", 1'b0, 32'h410, 32'h0,        32'hDEADBEEF);

    // Core store then load.
    bus.i_data_addr_M = 32'h20; bus.i_write_data_M = 32'h12345678; bus.i_mem_write_M = 1'b1;
    tick();
    bus.i_mem_write_M = 1'b0;
    tick();
    chk("core st_ld", bus.o_read_data_M, 32'h12345678);

    // Read-before-write on the same index.
    bus.i_data_addr_M = 32'h24; bus.i_write_data_M = 32'h11111111; bus.i_mem_write_M = 1'b1;
    tick();
    bus.i_write_data_M = 32'hA5A5A5A5;
    tick();
    chk("rbw old", bus.o_read_data_M, 32'h11111111);
    bus.i_mem_write_M = 1'b0;
    tick();
    chk("rbw new", bus.o_read_data_M, 32'hA5A5A5A5);

    // Out-of-range store: dropped (would alias index 0), reads 0, sticky error.
    bus.i_data_addr_M = 32'h0;
    tick();
    chk("pre err",  {31'd0, bus.o_range_err}, 32'd0);
    chk("pre rd0",  bus.o_read_data_M, 32'h0BADC0DE);
    bus.i_data_addr_M = 32'h400; bus.i_write_data_M = 32'hCAFEF00D; bus.i_mem_write_M = 1'b1;
    tick();
    chk("oor rd",   bus.o_read_data_M, 32'd0);
    chk("oor err",  {31'd0, bus.o_range_err}, 32'd1);
    bus.i_data_addr_M = 32'h0; bus.i_mem_write_M = 1'b0;
    repeat (10) tick();
    chk("err sticky", {31'd0, bus.o_range_err}, 32'd1);
    chk("oor nowr",   bus.o_read_data_M, 32'h0BADC0DE);

    // Host preempts a core store in H_ACCESS; core load data is held.
    bus.i_host_cyc = 1'b1; bus.i_host_stb = 1'b1; bus.i_host_we = 1'b1;
    bus.i_host_addr = 32'h30; bus.i_host_wdata = 32'h1;
    tick();
    bus.i_host_cyc = 1'b0; bus.i_host_stb = 1'b0;
    bus.i_data_addr_M = 32'h30; bus.i_write_data_M = 32'h2; bus.i_mem_write_M = 1'b1;
    chk("pre stall", {31'd0, bus.o_stall_M}, 32'd1);
    tick();
    bus.i_mem_write_M = 1'b0;
    chk("pre hold", bus.o_read_data_M, 32'h0BADC0DE);
    chk("pre ack",  {31'd0, bus.o_host_ack}, 32'd1);
    tick();
    chk("pre ram",  bus.o_read_data_M, 32'h1);

    // Reset during H_ACCESS of a host write: write and ack suppressed.
    bus.i_data_addr_M = 32'h40; bus.i_write_data_M = 32'h44444444; bus.i_mem_write_M = 1'b1;
    tick();
    bus.i_mem_write_M = 1'b0;
    bus.i_host_cyc = 1'b1; bus.i_host_stb = 1'b1; bus.i_host_we = 1'b1;
    bus.i_host_addr = 32'h40; bus.i_host_wdata = 32'hFFFF0000;
    tick();
    bus.i_host_cyc = 1'b0; bus.i_host_stb = 1'b0;
    chk("rstm stall", {31'd0, bus.o_stall_M}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rstm ack",    {31'd0, bus.o_host_ack}, 32'd0);
    chk("rstm stall0", {31'd0, bus.o_stall_M}, 32'd0);
    chk("rstm rd",     bus.o_read_data_M, 32'd0);
    chk("rstm err",    {31'd0, bus.o_range_err}, 32'd0);
    chk("rstm hrdata", bus.o_host_rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("rstm noack",  {31'd0, bus.o_host_ack}, 32'd0);
    chk("rstm ram",    bus.o_read_data_M, 32'h44444444);
    host_op("h_rd40", 1'b0, 32'h40, 32'h0, 32'h44444444);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
